// File: rtl/rgb_exposure_stats.sv
// Per-frame exposure statistics for the RGB pixel stream: windowed luma sum,
// pixel/saturated/dark counts, and a sequential divider for the mean luma.
module rgb_exposure_stats #(
  parameter int H_START    = 160,
  parameter int H_END      = 479,
  parameter int V_START    = 120,
  parameter int V_END      = 359,
  parameter int SAT_LEVEL  = 250,
  parameter int DARK_LEVEL = 5
) (
  input  logic        VGA_CLK,
  input  logic        RESET_N,
  input  logic        READ_Request,
  input  logic        VGA_VS,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  output logic [31:0] oLumaSum,
  output logic [19:0] oPixCount,
  output logic [19:0] oSatCount,
  output logic [19:0] oDarkCount,
  output logic [7:0]  oMeanLuma,
  output logic        oStatValid,
  output logic        oBusy,
  output logic [1:0]  o_dbg_state
);

  localparam logic [10:0] LP_H_START = 11'(H_START);
  localparam logic [10:0] LP_H_END   = 11'(H_END);
  localparam logic [10:0] LP_V_START = 11'(V_START);
  localparam logic [10:0] LP_V_END   = 11'(V_END);
  localparam logic [7:0]  LP_SAT     = 8'(SAT_LEVEL);
  localparam logic [7:0]  LP_DARK    = 8'(DARK_LEVEL);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

  // Pixel handshake: READ_Request is a valid-only strobe; a pixel is taken on
  // every rising edge where it is high, and there is no backpressure.
  logic        r_vs_d, r_rr_d;
  logic [10:0] r_x, r_y;
  logic        w_f;
  logic [9:0]  w_luma10;
  logic        w_in_win;

  assign w_f      = ~VGA_VS & r_vs_d;
  assign w_luma10 = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
  assign w_in_win = READ_Request &&
                    (r_x >= LP_H_START) && (r_x <= LP_H_END) &&
                    (r_y >= LP_V_START) && (r_y <= LP_V_END);

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vs_d <= 1'b1;
      r_rr_d <= 1'b0;
      r_x    <= 11'd0;
      r_y    <= 11'd0;
    end else begin
      r_vs_d <= VGA_VS;
      r_rr_d <= READ_Request;
      if (!READ_Request)       r_x <= 11'd0;
      else if (r_x != 11'h7FF) r_x <= r_x + 11'd1;
      if (w_f)                                         r_y <= 11'd0;
      else if (r_rr_d && !READ_Request && r_y != 11'h7FF) r_y <= r_y + 11'd1;
    end
  end

  logic [7:0] r_s1_luma;
  logic       r_s1_win;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1_luma <= 8'd0;
      r_s1_win  <= 1'b0;
    end else begin
      r_s1_luma <= w_luma10[9:2];
      r_s1_win  <= w_in_win;
    end
  end

  logic [31:0] r_acc_sum, r_snap_sum, w_sum_nx;
  logic [19:0] r_acc_cnt, r_snap_cnt, w_cnt_nx;
  logic [19:0] r_acc_sat, r_snap_sat, w_sat_nx;
  logic [19:0] r_acc_dark, r_snap_dark, w_dark_nx;
  logic        w_sat_hit, w_dark_hit;

  // The stage-1 pixel is folded into the next-value so that a pixel still in
  // flight at the frame boundary lands in the snapshot of the old frame.
  assign w_sat_hit  = r_s1_win && (r_s1_luma >= LP_SAT);
  assign w_dark_hit = r_s1_win && (r_s1_luma <= LP_DARK);
  assign w_sum_nx   = r_acc_sum + (r_s1_win ? {24'd0, r_s1_luma} : 32'd0);
  assign w_cnt_nx   = (r_s1_win && r_acc_cnt != 20'hFFFFF) ? r_acc_cnt + 20'd1 : r_acc_cnt;
  assign w_sat_nx   = (w_sat_hit && r_acc_sat != 20'hFFFFF) ? r_acc_sat + 20'd1 : r_acc_sat;
  assign w_dark_nx  = (w_dark_hit && r_acc_dark != 20'hFFFFF) ? r_acc_dark + 20'd1 : r_acc_dark;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc_sum   <= 32'd0;
      r_acc_cnt   <= 20'd0;
      r_acc_sat   <= 20'd0;
      r_acc_dark  <= 20'd0;
      r_snap_sum  <= 32'd0;
      r_snap_cnt  <= 20'd0;
      r_snap_sat  <= 20'd0;
      r_snap_dark <= 20'd0;
    end else if (w_f) begin
      r_acc_sum   <= 32'd0;
      r_acc_cnt   <= 20'd0;
      r_acc_sat   <= 20'd0;
      r_acc_dark  <= 20'd0;
      r_snap_sum  <= w_sum_nx;
      r_snap_cnt  <= w_cnt_nx;
      r_snap_sat  <= w_sat_nx;
      r_snap_dark <= w_dark_nx;
    end else begin
      r_acc_sum   <= w_sum_nx;
      r_acc_cnt   <= w_cnt_nx;
      r_acc_sat   <= w_sat_nx;
      r_acc_dark  <= w_dark_nx;
    end
  end

  state_t      r_state, w_state_nx;
  logic [4:0]  r_bit;
  logic [31:0] r_dvd;
  logic [19:0] r_rem;
  logic [20:0] w_trial, w_rem_nx;
  logic        w_ge;
  logic [31:0] w_quo_nx;
  logic        w_load;
  logic [7:0]  w_quo_out;

  // r_dvd shifts the dividend out MSB-first and the quotient in LSB-first.
  assign w_trial  = {r_rem, r_dvd[31]};
  assign w_ge     = w_trial >= {1'b0, r_snap_cnt};
  assign w_rem_nx = w_ge ? (w_trial - {1'b0, r_snap_cnt}) : w_trial;
  assign w_quo_nx = {r_dvd[30:0], w_ge};

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_quo_out  = 8'd0;
    if (w_f) begin
      if (w_cnt_nx == 20'd0) begin
        w_state_nx = S_DONE;
        w_load     = 1'b1;
      end else begin
        w_state_nx = S_DIV;
      end
    end else begin
      case (r_state)
        S_DIV: begin
          if (r_bit == 5'd31) begin
            w_state_nx = S_DONE;
            w_load     = 1'b1;
            w_quo_out  = (|w_quo_nx[31:8]) ? 8'hFF : w_quo_nx[7:0];
          end
        end
        S_DONE:  w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_bit   <= 5'd0;
      r_dvd   <= 32'd0;
      r_rem   <= 20'd0;
    end else begin
      r_state <= w_state_nx;
      if (w_f) begin
        r_bit <= 5'd0;
        r_dvd <= w_sum_nx;
        r_rem <= 20'd0;
      end else if (r_state == S_DIV) begin
        r_bit <= r_bit + 5'd1;
        r_dvd <= w_quo_nx;
        r_rem <= w_rem_nx[19:0];
      end
    end
  end

  logic [31:0] r_o_sum;
  logic [19:0] r_o_cnt, r_o_sat, r_o_dark;
  logic [7:0]  r_o_mean;
  logic        r_o_valid;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_o_sum   <= 32'd0;
      r_o_cnt   <= 20'd0;
      r_o_sat   <= 20'd0;
      r_o_dark  <= 20'd0;
      r_o_mean  <= 8'd0;
      r_o_valid <= 1'b0;
    end else begin
      r_o_valid <= w_load;
      if (w_load) begin
        r_o_sum  <= w_f ? w_sum_nx  : r_snap_sum;
        r_o_cnt  <= w_f ? w_cnt_nx  : r_snap_cnt;
        r_o_sat  <= w_f ? w_sat_nx  : r_snap_sat;
        r_o_dark <= w_f ? w_dark_nx : r_snap_dark;
        r_o_mean <= w_quo_out;
      end
    end
  end

  assign oLumaSum    = r_o_sum;
  assign oPixCount   = r_o_cnt;
  assign oSatCount   = r_o_sat;
  assign oDarkCount  = r_o_dark;
  assign oMeanLuma   = r_o_mean;
  assign oStatValid  = r_o_valid;
  assign oBusy       = (r_state == S_DIV);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rgb_exposure_stats.sv
// Directed bench for rgb_exposure_stats on a small window; a frame-level
// statistics model predicts every output on every cycle.
module tb_rgb_exposure_stats;

  localparam int HS = 3;
  localparam int HE = 10;
  localparam int VS0 = 1;
  localparam int VE = 4;
  localparam int NLINES = 7;
  localparam int LLEN = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rr;
  logic        vs;
  logic [7:0]  r_in, g_in, b_in;
  logic [31:0] o_sum;
  logic [19:0] o_cnt, o_sat, o_dark;
  logic [7:0]  o_mean;
  logic        o_valid, o_busy;
  logic [1:0]  o_dbg;

  rgb_exposure_stats #(
    .H_START(HS), .H_END(HE), .V_START(VS0), .V_END(VE),
    .SAT_LEVEL(250), .DARK_LEVEL(5)
  ) dut (
    .VGA_CLK(clk), .RESET_N(rst_n), .READ_Request(rr), .VGA_VS(vs),
    .iRed(r_in), .iGreen(g_in), .iBlue(b_in),
    .oLumaSum(o_sum), .oPixCount(o_cnt), .oSatCount(o_sat), .oDarkCount(o_dark),
    .oMeanLuma(o_mean), .oStatValid(o_valid), .oBusy(o_busy), .o_dbg_state(o_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;

  // frame model: running totals, pending result, and currently shown result
  longint m_sum;
  int m_cnt, m_sat, m_dark;
  bit pend;
  int due;
  longint p_sum;
  int p_cnt, p_sat, p_dark, p_mean;
  longint h_sum;
  int h_cnt, h_sat, h_dark, h_mean;
  int b_start, b_end;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_cnt = 0; m_sat = 0; m_dark = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rr_i, input logic vs_i, input logic [23:0] c);
    tick();
    rr = rr_i;
    vs = vs_i;
    r_in = c[23:16];
    g_in = c[15:8];
    b_in = c[7:0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, 24'd0);
  endtask

  task automatic pixel(input int x, input int y, input logic [23:0] c);
    int lu;
    drive(1'b1, 1'b1, c);
    lu = (int'(c[23:16]) + 2 * int'(c[15:8]) + int'(c[7:0])) / 4;
    if (x >= HS && x <= HE && y >= VS0 && y <= VE) begin
      m_sum += lu;
      m_cnt++;
      if (lu >= 250) m_sat++;
      if (lu <= 5) m_dark++;
    end
  endtask

  task automatic vs_fall();
    int f;
    bit was_busy;
    drive(1'b0, 1'b0, 24'd0);
    f = cyc;
    pend = 1'b1;
    p_sum = m_sum; p_cnt = m_cnt; p_sat = m_sat; p_dark = m_dark;
    p_mean = (m_cnt == 0) ? 0 : int'(m_sum / m_cnt);
    if (p_mean > 255) p_mean = 255;
    due = (m_cnt == 0) ? f + 1 : f + 33;
    was_busy = (f >= b_start && f <= b_end);
    if (was_busy) b_end = (m_cnt == 0) ? f : f + 32;
    else if (m_cnt != 0) begin
      b_start = f + 1;
      b_end = f + 32;
    end
    model_clear();
  endtask

  function automatic logic [23:0] pix(input int kind, input int x, input int y);
    logic [23:0] c;
    c = 24'd0;
    case (kind)
      0: c = {8'd100, 8'd100, 8'd100};
      1: c = {8'd200, 8'd100, 8'd0};
      2: c = {8'd255, 8'd255, 8'd255};
      3: c = 24'd0;
      4: c = (x == HS && y == VS0) ? {8'd200, 8'd200, 8'd200} : 24'd0;
      5: c = (x == HS - 1 && y == VS0) ? {8'd200, 8'd200, 8'd200} : 24'd0;
      default: begin
        c = {8'((x * 40 + y * 7) % 256), 8'((x * 23 + y * 50) % 256), 8'((x * 91 + y * 3) % 256)};
        if (x == HS && y == VS0) c = {8'd255, 8'd255, 8'd255};
        if (x == HE && y == VE) c = 24'd0;
      end
    endcase
    return c;
  endfunction

  task automatic lines(input int kind);
    for (int y = 0; y < NLINES; y++) begin
      for (int x = 0; x < LLEN; x++) pixel(x, y, pix(kind, x, y));
      idle(3);
    end
  endtask

  task automatic frame(input int kind);
    lines(kind);
    vs_fall();
    idle(40);
  endtask

  task automatic lit(input string nm, input int cnt, input longint sum, input int mean,
                     input int sat, input int dark);
    chk({nm, "_cnt"}, 64'(o_cnt), 64'(cnt));
    chk({nm, "_sum"}, 64'(o_sum), 64'(sum));
    chk({nm, "_mean"}, 64'(o_mean), 64'(mean));
    chk({nm, "_sat"}, 64'(o_sat), 64'(sat));
    chk({nm, "_dark"}, 64'(o_dark), 64'(dark));
  endtask

  task automatic reset_model();
    pend = 1'b0;
    h_sum = 0; h_cnt = 0; h_sat = 0; h_dark = 0; h_mean = 0;
    b_start = 1; b_end = 0;
    model_clear();
  endtask

  // per-cycle compare against the frame model
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      if (done) break;
      exp_v = 1'b0;
      if (pend && cyc == due) begin
        h_sum = p_sum; h_cnt = p_cnt; h_sat = p_sat; h_dark = p_dark; h_mean = p_mean;
        pend = 1'b0;
        exp_v = 1'b1;
      end
      chk("stat_valid", 64'(o_valid), 64'(exp_v));
      chk("busy", 64'(o_busy), 64'((cyc >= b_start && cyc <= b_end) ? 1 : 0));
      chk("luma_sum", 64'(o_sum), 64'(h_sum));
      chk("pix_count", 64'(o_cnt), 64'(h_cnt));
      chk("sat_count", 64'(o_sat), 64'(h_sat));
      chk("dark_count", 64'(o_dark), 64'(h_dark));
      chk("mean_luma", 64'(o_mean), 64'(h_mean));
      chk("dbg_state_known", 64'((^o_dbg) === 1'bx), 64'(0));
    end
  end

  initial begin
    reset_model();
    rst_n = 1'b0; rr = 1'b0; vs = 1'b1;
    r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
    idle(3);
    lit("reset", 0, 0, 0, 0, 0);
    chk("reset_valid", 64'(o_valid), 64'(0));
    rst_n = 1'b1;
    idle(3);

    frame(0); lit("gray100", 32, 3200, 100, 0, 0);
    frame(1); lit("rgb_200_100_0", 32, 3200, 100, 0, 0);
    frame(2); lit("white", 32, 8160, 255, 32, 0);
    frame(3); lit("black", 32, 0, 0, 0, 32);
    frame(4); lit("edge_in", 32, 200, 6, 0, 31);
    frame(5); lit("edge_out", 32, 0, 0, 0, 32);
    frame(6);

    // frame with no valid pixels: result on the cycle after the boundary
    vs_fall();
    idle(40);
    lit("empty", 0, 0, 0, 0, 0);

    // second boundary 10 cycles after the first aborts the running division
    lines(6);
    vs_fall();
    idle(1);
    pixel(0, 0, {8'd40, 8'd80, 8'd120});
    idle(1);
    for (int x = 0; x < 4; x++) pixel(x, 1, {8'd40, 8'd80, 8'd120});
    idle(2);
    vs_fall();
    idle(45);
    lit("abort", 1, 80, 80, 0, 0);

    // reset in the middle of a division
    lines(0);
    vs_fall();
    idle(14);
    tick();
    rst_n = 1'b0;
    reset_model();
    #1;
    lit("mid_div_reset", 0, 0, 0, 0, 0);
    idle(3);
    rst_n = 1'b1;
    idle(5);
    frame(1);
    lit("after_reset", 32, 3200, 100, 0, 0);

    idle(2);
    done = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
